// File: rtl/galcounter_pkg.sv
// Shared constants and load clamping for the galcounter family.
package galcounter_pkg;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

    localparam int unsigned MaxWidth = 16;

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [MaxWidth:0] clamp(input logic [MaxWidth:0] d,
                                                input int unsigned modulus);
        if ({15'b0, d} >= modulus) begin
            return 17'(modulus - 1);
        end
        return d;
    endfunction

endpackage

// File: rtl/galcounter_device.sv
// Pin-level wrapper: one standalone 4-bit modulo-16 wrapping stage on the device pins.
module galcounter_device (
    input  logic [11:1]  P,
    output logic [18:14] Q
);

    // P[7] is CarryIn: tie high standalone. If cascaded from another device's Q[18],
    // this stage steps one cycle after the lower stage wraps (1-cycle skew per stage).
    galcounter_n #(
        .WIDTH   (4),
        .MODULUS (16),
        .SATURATE(1'b0)
    ) u_counter (
        .Clock      (P[1]),
        .Reset      (P[2]),
        .Set        (P[3]),
        .Clear      (P[4]),
        .OE         (P[5]),
        .Up         (P[6]),
        .CarryIn    (P[7]),
        .D          (P[11:8]),
        .counter_out(Q[17:14]),
        .Carry      (Q[18])
    );

endmodule

// File: rtl/galcounter_next.sv
// Combinational next-count and terminal-event logic for one counter stage.
module galcounter_next
    import galcounter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 1 << WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    input  logic             mode,
    output logic [WIDTH-1:0] next_value,
    output logic             terminal
);

    localparam logic [WIDTH:0] MaxVal = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] One    = {{WIDTH{1'b0}}, 1'b1};

    // One spare bit so the increment can never overflow before the range test.
    logic [WIDTH:0] value_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        value_ext = {1'b0, value};
        sum       = value_ext;
        terminal  = 1'b0;
        unique case (up)
            UP: begin
                if (value_ext >= MaxVal) begin
                    terminal = 1'b1;
                    sum      = (mode == WRAP) ? '0 : MaxVal;
                end else begin
                    sum = value_ext + One;
                end
            end
            DOWN: begin
                if (value_ext == '0) begin
                    terminal = 1'b1;
                    sum      = (mode == SAT) ? value_ext : MaxVal;
                end else begin
                    sum = value_ext - One;
                end
            end
        endcase
        next_value = sum[WIDTH-1:0];
    end

endmodule

// File: rtl/galcounter_n.sv
// WIDTH-bit modulo counter with load, clear, enable, direction and cascade carry.
module galcounter_n
    import galcounter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 1 << WIDTH,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Set,
    input  logic             Clear,
    input  logic             OE,
    input  logic             Up,
    input  logic             CarryIn,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] counter_out,
    output logic             Carry
);

    if (WIDTH < 1 || WIDTH > MaxWidth) begin : g_bad_width
        $error("galcounter_n: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("galcounter_n: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] next_value;
    logic             terminal;

    galcounter_next #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_next (
        .value     (count_q),
        .up        (Up),
        .mode      (SATURATE),
        .next_value(next_value),
        .terminal  (terminal)
    );

    // Set > Clear > count > hold; Carry only ever reflects a count edge.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (Set) begin
            count_d = WIDTH'(clamp(17'(D), MODULUS));
        end else if (Clear) begin
            count_d = '0;
        end else if (!OE && CarryIn) begin
            count_d = next_value;
            carry_d = terminal;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign counter_out = count_q;
    assign Carry       = carry_q;

endmodule

// File: tb/tb_galcounter_n.sv
// Scoreboard bench: stimulus queues expected results, a monitor compares after each edge.
module tb_galcounter_n;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic Reset;

    // sel 0: wrap, MODULUS=10
    logic       w_set, w_clr, w_oe, w_up, w_cin;
    logic [3:0] w_d, w_cnt;
    logic       w_carry;
    // sel 1: saturate, MODULUS=10
    logic       s_set, s_clr, s_oe, s_up;
    logic [3:0] s_d, s_cnt;
    logic       s_carry;
    // sel 2: two-stage decade cascade
    logic       c_set, c_clr, c_oe, c_up;
    logic [3:0] c_d, lo_cnt, hi_cnt;
    logic       lo_carry, hi_carry;
    // sel 3: pin-level device, modulo 16
    logic       v_set, v_clr, v_oe, v_up, v_cin;
    logic [3:0] v_d;
    logic [11:1] dev_p;
    logic [18:14] dev_q;

    assign dev_p = {v_d, v_cin, v_up, v_oe, v_clr, v_set, Reset, Clock};

    galcounter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .Clock(Clock), .Reset(Reset), .Set(w_set), .Clear(w_clr), .OE(w_oe), .Up(w_up),
        .CarryIn(w_cin), .D(w_d), .counter_out(w_cnt), .Carry(w_carry)
    );

    galcounter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .Clock(Clock), .Reset(Reset), .Set(s_set), .Clear(s_clr), .OE(s_oe), .Up(s_up),
        .CarryIn(1'b1), .D(s_d), .counter_out(s_cnt), .Carry(s_carry)
    );

    // Upper decade steps on the edge after the lower Carry: 1-cycle skew.
    galcounter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo (
        .Clock(Clock), .Reset(Reset), .Set(c_set), .Clear(c_clr), .OE(c_oe), .Up(c_up),
        .CarryIn(1'b1), .D(c_d), .counter_out(lo_cnt), .Carry(lo_carry)
    );

    galcounter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi (
        .Clock(Clock), .Reset(Reset), .Set(c_set), .Clear(c_clr), .OE(c_oe), .Up(c_up),
        .CarryIn(lo_carry), .D(c_d), .counter_out(hi_cnt), .Carry(hi_carry)
    );

    galcounter_device u_dev (
        .P(dev_p),
        .Q(dev_q)
    );

    typedef struct {
        int         sel;
        logic [7:0] cnt;
        logic [1:0] carry;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] ac;
            logic [1:0] acy;
            e = sb.pop_front();
            case (e.sel)
                0:       begin ac = {4'b0, w_cnt};      acy = {1'b0, w_carry};     end
                1:       begin ac = {4'b0, s_cnt};      acy = {1'b0, s_carry};     end
                2:       begin ac = {hi_cnt, lo_cnt};   acy = {hi_carry, lo_carry}; end
                default: begin ac = {4'b0, dev_q[17:14]}; acy = {1'b0, dev_q[18]}; end
            endcase
            n_checks++;
            if (ac !== e.cnt || acy !== e.carry) begin
                n_fail++;
                $display("FAIL %s: got count=%h carry=%b, expected count=%h carry=%b",
                         e.name, ac, acy, e.cnt, e.carry);
            end
        end
    endtask

    always @(posedge Clock) begin
        #1;
        drain();
    end

    always @(sample_ev) drain();

    task automatic push(input int sel, input logic [7:0] cnt, input logic [1:0] carry,
                        input string name);
        exp_t e;
        e.sel = sel; e.cnt = cnt; e.carry = carry; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drv(input int sel, input logic set, input logic clr, input logic oe,
                       input logic up, input logic cin, input logic [3:0] d);
        case (sel)
            0: begin w_set = set; w_clr = clr; w_oe = oe; w_up = up; w_cin = cin; w_d = d; end
            1: begin s_set = set; s_clr = clr; s_oe = oe; s_up = up; s_d = d; end
            2: begin c_set = set; c_clr = clr; c_oe = oe; c_up = up; c_d = d; end
            default: begin
                v_set = set; v_clr = clr; v_oe = oe; v_up = up; v_cin = cin; v_d = d;
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic step(input int sel, input logic set, input logic clr, input logic oe,
                        input logic up, input logic cin, input logic [3:0] d,
                        input logic [7:0] ecnt, input logic [1:0] ecy, input string name);
        drv(sel, set, clr, oe, up, cin, d);
        push(sel, ecnt, ecy, name);
        cycle();
    endtask

    initial begin
        Reset = 1'b1;
        for (int s = 0; s < 4; s++) drv(s, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        #2;
        for (int s = 0; s < 4; s++) push(s, 8'h00, 2'b00, "reset_state");
        -> sample_ev;
        @(negedge Clock);
        Reset = 1'b0;

        // Async reset from a count of 7, Set held high to show it is overridden
        step(0, 1, 0, 1, 1, 1, 4'd7, 8'd7, 2'b00, "load7");
        #2 Reset = 1'b1;
        #1;
        push(0, 8'd0, 2'b00, "rst_async");
        -> sample_ev;
        @(negedge Clock);
        push(0, 8'd0, 2'b00, "rst_held");
        cycle();
        Reset = 1'b0;

        // Wrap up: 1..9,0,1,2 with Carry on the 0
        step(0, 0, 1, 1, 1, 1, 4'd0, 8'd0, 2'b00, "clear");
        for (int k = 1; k <= 12; k++)
            step(0, 0, 0, 0, 1, 1, 4'd0, 8'(k % 10), {1'b0, k == 10}, "wrap_up");

        // Wrap down from 2: 1,0,9,8 with Carry on the 9
        step(0, 1, 0, 1, 0, 1, 4'd2, 8'd2, 2'b00, "load2");
        step(0, 0, 0, 0, 0, 1, 4'd0, 8'd1, 2'b00, "down_1");
        step(0, 0, 0, 0, 0, 1, 4'd0, 8'd0, 2'b00, "down_0");
        step(0, 0, 0, 0, 0, 1, 4'd0, 8'd9, 2'b01, "down_wrap9");
        step(0, 0, 0, 0, 0, 1, 4'd0, 8'd8, 2'b00, "down_8");
        step(0, 0, 0, 0, 0, 0, 4'd0, 8'd8, 2'b00, "cin0_hold");
        step(0, 1, 0, 0, 0, 0, 4'd3, 8'd3, 2'b00, "cin0_set");
        step(0, 0, 0, 1, 1, 1, 4'd0, 8'd3, 2'b00, "oe_hold");

        // Priority and clamp
        step(0, 1, 1, 0, 1, 1, 4'd14, 8'd9, 2'b00, "set_clr_clamp14");
        step(0, 0, 1, 0, 1, 1, 4'd0, 8'd0, 2'b00, "clear_over_count");
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, 1, 1, 1, 4'd0, 8'd0, 2'b00, "oe_off_hold");
        step(0, 1, 0, 1, 1, 1, 4'd10, 8'd9, 2'b00, "clamp_eq_mod");
        step(0, 1, 0, 1, 1, 1, 4'd9, 8'd9, 2'b00, "load_max");
        step(0, 1, 0, 0, 1, 1, 4'd4, 8'd4, 2'b00, "set_over_wrap");
        drv(0, 0, 0, 1, 1, 1, 4'd0);

        // Saturate: 9,9,9 with Carry 0,1,1, then down to 8
        step(1, 1, 0, 1, 1, 1, 4'd8, 8'd8, 2'b00, "sat_load8");
        step(1, 0, 0, 0, 1, 1, 4'd0, 8'd9, 2'b00, "sat_up9");
        step(1, 0, 0, 0, 1, 1, 4'd0, 8'd9, 2'b01, "sat_hold_hi1");
        step(1, 0, 0, 0, 1, 1, 4'd0, 8'd9, 2'b01, "sat_hold_hi2");
        step(1, 0, 0, 0, 0, 1, 4'd0, 8'd8, 2'b00, "sat_down8");
        step(1, 1, 0, 1, 0, 1, 4'd0, 8'd0, 2'b00, "sat_load0");
        step(1, 0, 0, 0, 0, 1, 4'd0, 8'd0, 2'b01, "sat_hold_lo");
        step(1, 0, 0, 0, 1, 1, 4'd0, 8'd1, 2'b00, "sat_up1");
        drv(1, 0, 0, 1, 1, 1, 4'd0);

        // Default modulus through the pins: 14,15,0(carry),1
        step(3, 1, 0, 1, 1, 1, 4'd14, 8'd14, 2'b00, "dev_load14");
        step(3, 0, 0, 0, 1, 1, 4'd0, 8'd15, 2'b00, "dev_15");
        step(3, 0, 0, 0, 1, 1, 4'd0, 8'd0, 2'b01, "dev_wrap0");
        step(3, 0, 0, 0, 1, 1, 4'd0, 8'd1, 2'b00, "dev_1");
        drv(3, 0, 0, 1, 1, 1, 4'd0);

        // Cascade: lower Carry on edges 10 and 20, upper steps on 11 and 21
        step(2, 0, 1, 1, 1, 1, 4'd0, 8'h00, 2'b00, "casc_clear");
        for (int k = 1; k <= 25; k++) begin
            int hi;
            hi = (k >= 21) ? 2 : (k >= 11) ? 1 : 0;
            step(2, 0, 0, 0, 1, 1, 4'd0, 8'(hi * 16 + (k % 10)),
                 {1'b0, (k == 10) || (k == 20)}, "cascade");
        end
        drv(2, 0, 0, 1, 1, 1, 4'd0);

        cycle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
